// File: rtl/scan_pkg.sv
// Shared constants, types and helpers for the seven-segment digit scan controller.
package scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;
  localparam int DATA_W     = 8;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  typedef logic [DATA_W-1:0] byte_t;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input logic [DIGIT_W-1:0] sel);
    return ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Write port of the digit register bank; the master side writes, the controller is the slave.
interface digit_scan_ctrl_if;
  import scan_pkg::*;

  logic                 wr_en;
  logic [DIGIT_W-1:0]   wr_addr;
  byte_t                wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 while running and flags the last cycle of each slot.
module scan_tick_gen #(
  parameter  int PRESCALE = 100000,
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Byte bank plus scan FSM driving the 8:1 segment mux select and the matching dead-timed anode enables.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int DEAD     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digit_scan_ctrl_if.slave      wr,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output byte_t                 out0,
  output byte_t                 out1,
  output byte_t                 out2,
  output byte_t                 out3,
  output byte_t                 out4,
  output byte_t                 out5,
  output byte_t                 out6,
  output byte_t                 out7,
  output logic [DIGIT_W-1:0]    sel3,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  scan_state_t           state, state_next;
  logic [DIGIT_W-1:0]    sel_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  clr, run, tick;
  logic [NUM_DIGITS-1:0] anode_next;
  byte_t                 bank [NUM_DIGITS];

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (run),
    .tick  (tick),
    .cnt   (cnt)
  );

  // Leaving or entering SCAN always restarts the slot; sel3 is held across idle periods.
  always_comb begin
    state_next = state;
    sel_next   = sel3;
    clr        = 1'b1;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          clr = 1'b0;
          run = 1'b1;
          if (tick) sel_next = sel3 + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    cnt_next = (clr || tick) ? '0 : cnt + 1'b1;
  end

  // Anodes are computed from next-state values so they switch on the same edge as sel3.
  always_comb begin
    anode_next = '1;
    if (state_next == SCAN && int'(cnt_next) >= DEAD && !blank_mask[sel_next])
      anode_next = anode_onehot_n(sel_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel3       <= '0;
      anode_n    <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      sel3       <= sel_next;
      anode_n    <= anode_next;
      frame_done <= tick && (sel3 == DIGIT_W'(NUM_DIGITS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) bank[i] <= '0;
    end else if (wr.wr_en) begin
      bank[wr.wr_addr] <= wr.wr_data;
    end
  end

  assign out0 = bank[0];
  assign out1 = bank[1];
  assign out2 = bank[2];
  assign out3 = bank[3];
  assign out4 = bank[4];
  assign out5 = bank[5];
  assign out6 = bank[6];
  assign out7 = bank[7];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with PRESCALE=4, DEAD=1 (4-cycle slots, 1 dead cycle each).
module tb_digit_scan_ctrl;
  import scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] blank_mask = 8'h00;
  byte_t      out0, out1, out2, out3, out4, out5, out6, out7;
  logic [2:0] sel3;
  logic [7:0] anode_n;
  logic       frame_done;
  byte_t      outs [8];

  int checks = 0;
  int errors = 0;

  digit_scan_ctrl_if wr_if ();

  digit_scan_ctrl #(.PRESCALE(4), .DEAD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .enable     (enable),
    .blank_mask (blank_mask),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .sel3       (sel3),
    .anode_n    (anode_n),
    .frame_done (frame_done)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] addr, input byte_t data);
    wr_if.wr_en   = en;
    wr_if.wr_addr = addr;
    wr_if.wr_data = data;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_out%0d got %h exp 00", i, outs[i]);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (sel3 !== 3'd0 || anode_n !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc%0d got sel=%0d an=%h fd=%b exp sel=0 an=FF fd=0",
                 k, sel3, anode_n, frame_done);
      end
    end
  endtask

  task automatic test_write();
    applyStimulus(1'b1, 3'd3, 8'hA5);
    step();
    applyStimulus(1'b0, 3'd0, 8'h00);
    checks++;
    if (out3 !== 8'hA5 || out2 !== 8'h00 || out4 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL write_a5 got out2=%h out3=%h out4=%h exp 00 A5 00", out2, out3, out4);
    end
  endtask

  // Full frame from reset, with a mid-frame write to the digit currently on display.
  task automatic test_scan();
    int fd_seen = 0;
    logic [7:0] exp_an;
    enable = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (s == 3 && c == 1) begin
          applyStimulus(1'b0, 3'd0, 8'h00);
          checks++;
          if (out3 !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL write_during_scan got %h exp 3C", out3);
          end
        end
        exp_an = (c == 0) ? 8'hFF : ~(8'h01 << s);
        if (frame_done) fd_seen++;
        checks++;
        if (sel3 !== 3'(s) || anode_n !== exp_an) begin
          errors++;
          $display("[TB] FAIL scan s%0d c%0d got sel=%0d an=%h exp sel=%0d an=%h",
                   s, c, sel3, anode_n, s, exp_an);
        end
        if (s == 3 && c == 0) applyStimulus(1'b1, 3'd3, 8'h3C);
      end
    end
    step();
    checks++;
    if (sel3 !== 3'd0 || anode_n !== 8'hFF || frame_done !== 1'b1 || fd_seen != 0) begin
      errors++;
      $display("[TB] FAIL frame_wrap got sel=%0d an=%h fd=%b early=%0d exp sel=0 an=FF fd=1 early=0",
               sel3, anode_n, frame_done, fd_seen);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || anode_n !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL frame_pulse_width got fd=%b an=%h exp fd=0 an=FE", frame_done, anode_n);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_blank();
    logic [7:0] exp_an;
    enable = 1'b0;
    pulse_reset();
    blank_mask = 8'h04;
    enable = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_an = (c == 0 || s == 2) ? 8'hFF : ~(8'h01 << s);
        checks++;
        if (sel3 !== 3'(s) || anode_n !== exp_an) begin
          errors++;
          $display("[TB] FAIL blank s%0d c%0d got sel=%0d an=%h exp sel=%0d an=%h",
                   s, c, sel3, anode_n, s, exp_an);
        end
      end
    end
    blank_mask = 8'h00;
  endtask

  task automatic test_pause();
    enable = 1'b0;
    pulse_reset();
    enable = 1'b1;
    for (int k = 0; k < 23; k++) step();
    checks++;
    if (sel3 !== 3'd5 || anode_n !== 8'hDF) begin
      errors++;
      $display("[TB] FAIL pause_pre got sel=%0d an=%h exp sel=5 an=DF", sel3, anode_n);
    end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (sel3 !== 3'd5 || anode_n !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_idle cyc%0d got sel=%0d an=%h fd=%b exp sel=5 an=FF fd=0",
                 k, sel3, anode_n, frame_done);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (sel3 !== 3'd5 || anode_n !== ((c == 0) ? 8'hFF : 8'hDF)) begin
        errors++;
        $display("[TB] FAIL resume c%0d got sel=%0d an=%h exp sel=5 an=%h",
                 c, sel3, anode_n, (c == 0) ? 8'hFF : 8'hDF);
      end
    end
    step();
    checks++;
    if (sel3 !== 3'd6 || anode_n !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL resume_next got sel=%0d an=%h exp sel=6 an=FF", sel3, anode_n);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 3'd1, 8'h77);
    step();
    applyStimulus(1'b0, 3'd0, 8'h00);
    checks++;
    if (out1 !== 8'h77 || sel3 !== 3'd6 || anode_n !== 8'hBF) begin
      errors++;
      $display("[TB] FAIL pre_async got out1=%h sel=%0d an=%h exp 77 6 BF", out1, sel3, anode_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out1 !== 8'h00 || out3 !== 8'h00 || sel3 !== 3'd0 || anode_n !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got out1=%h out3=%h sel=%0d an=%h fd=%b exp 00 00 0 FF 0",
               out1, out3, sel3, anode_n, frame_done);
    end
    enable = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (sel3 !== 3'd0 || anode_n !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL post_async got sel=%0d an=%h exp sel=0 an=FF", sel3, anode_n);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 3'd0, 8'h00);
    test_reset();
    test_write();
    test_scan();
    test_blank();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
